// File: rtl/logic_result_stage.sv
// logic_result_stage: selects one of three upstream logic results (AND/OR/NOR)
// by in_op and buffers it, with zero and error flags, in a 2-entry FIFO.
// in_ready depends only on registered state, so out_ready has no path to it.
// Optional feature: define LOGIC_STATS_EN to build a saturating 16-bit count
// of output handshakes on stat_count; otherwise stat_count is tied to 0.
module logic_result_stage #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_s1,
    input  logic [WIDTH-1:0] in_s2,
    input  logic [WIDTH-1:0] in_s3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err,
    output logic [15:0]      stat_count
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             err;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     new_entry;
    entry_t     head;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       ready_en_q;
    logic       push;
    logic       pop;

    // in_ready stays low through reset and rises on the first edge after it.
    assign in_ready  = ready_en_q && (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Build the entry to capture: selected word, its zero flag, reserved-op error.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        new_entry = '0;
        unique case (op_e'(in_op))
            OP_AND:  new_entry.data = in_s1;
            OP_OR:   new_entry.data = in_s2;
            OP_NOR:  new_entry.data = in_s3;
            OP_RSVD: new_entry.err  = 1'b1;
            default: new_entry.err  = 1'b1;
        endcase
        new_entry.zero = (new_entry.data == '0);
    end

    // Next occupancy from the push/pop pair; simultaneous push and pop holds it.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage write on push.
    // NOTE: the entry array has no reset; out_* are masked while out_valid is 0,
    // so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Pointers, occupancy and ready enable; reset discards all entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            count_q    <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Head entry drives the outputs, forced to zero when nothing is held.
    assign head     = mem_q[rd_ptr_q];
    assign out_data = out_valid ? head.data : '0;
    assign out_zero = out_valid ? head.zero : 1'b0;
    assign out_err  = out_valid ? head.err  : 1'b0;

`ifdef LOGIC_STATS_EN
    logic [15:0] stat_q;
    logic [15:0] stat_d;

    // Saturating handshake counter.
    always_comb begin
        stat_d = stat_q;
        if (pop && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= 16'd0;
        else        stat_q <= stat_d;
    end

    assign stat_count = stat_q;
`else
    assign stat_count = 16'd0;
`endif

endmodule
